// File: rtl/io_uart_pkg.sv
// Shared types and frame constants for the UART byte-output bridge.
package io_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/io_byte_fifo.sv
// Synchronous FIFO with a non-wrapping level counter; a push while full is
// accepted only when a pop frees a slot on the same edge.
module io_byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage needs no reset: level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/io_uart_tx_bridge.sv
// Captures core byte strobes into a FIFO and serialises them as 8N1 frames,
// with back-to-back frames and a sticky overflow flag for dropped strobes.
module io_uart_tx_bridge
    import io_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        io_valid,
    input  logic [7:0]                  io_data,
    input  logic                        ovf_clr,
    output logic                        uart_tx,
    output logic                        busy,
    output logic                        fifo_full,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
);

    localparam int              BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      LAST_BIT  = 3'(UART_DATA_BITS - 1);

    tx_state_t     state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          baud_done;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          drop;
    logic          line_bit;

    // io_valid is a one-cycle strobe with no ready: the byte is either
    // taken on that edge or dropped and recorded in overflow.
    io_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (io_valid),
        .pop   (fifo_pop),
        .din   (io_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign baud_done = (baud_cnt == BAUD_LAST);
    assign fifo_pop  = !fifo_empty && ((state == IDLE) || (state == STOP && baud_done));
    assign drop      = io_valid && fifo_full && !fifo_pop;
    assign busy      = (state != IDLE) || (fifo_level != '0);

    always_comb begin
        line_bit = 1'b1;
        case (state)
            START:   line_bit = 1'b0;
            DATA:    line_bit = shift_reg[bit_idx];
            default: line_bit = 1'b1;
        endcase
    end

    // The line flop follows the state one cycle later, so frames stay
    // contiguous across a STOP->START transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            uart_tx   <= 1'b1;
        end else begin
            uart_tx <= line_bit;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (!fifo_empty) begin
                        shift_reg <= fifo_dout;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == LAST_BIT) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (!fifo_empty) begin
                            shift_reg <= fifo_dout;
                            state     <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A drop on the same edge as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_io_uart_tx_bridge.sv
// Directed and randomized bench for io_uart_tx_bridge, checked against a
// frame-level queue model and a line-decoding receiver.
module tb_io_uart_tx_bridge;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int FRAME = 10 * CPB;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic          io_valid = 1'b0;
    logic [7:0]    io_data  = 8'h00;
    logic          ovf_clr  = 1'b0;
    logic          uart_tx;
    logic          busy;
    logic          fifo_full;
    logic [LW-1:0] fifo_level;
    logic          overflow;

    int checks   = 0;
    int failures = 0;

    // Model: pending bytes, remaining cycles of the frame in progress, line.
    logic [7:0] m_fifo[$];
    logic [7:0] exp_q[$];
    int         m_rem  = 0;
    logic [7:0] m_cur  = 8'h00;
    logic       m_ovf  = 1'b0;
    logic       m_line = 1'b1;

    // Receiver
    logic       rx_active = 1'b0;
    int         rx_cnt    = 0;
    logic [7:0] rx_byte   = 8'h00;
    logic [7:0] rx_last   = 8'h00;
    logic       rx_prev   = 1'b1;
    int         frames    = 0;
    int         peak      = 0;

    always #5 clk = ~clk;

    io_uart_tx_bridge #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .io_valid   (io_valid),
        .io_data    (io_data),
        .ovf_clr    (ovf_clr),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line level implied by a frame with rem cycles left: start, 8 data LSB first, stop.
    function automatic logic line_for(input int rem, input logic [7:0] cur);
        int pos;
        int b;
        if (rem == 0) return 1'b1;
        pos = FRAME - rem;
        b   = pos / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return cur[b-1];
        return 1'b1;
    endfunction

    task automatic model_edge();
        logic nl;
        logic pop;
        nl  = line_for(m_rem, m_cur);
        pop = (m_fifo.size() > 0) && (m_rem <= 1);
        if (m_rem > 0) m_rem--;
        if (pop) begin
            m_cur = m_fifo.pop_front();
            m_rem = FRAME;
            exp_q.push_back(m_cur);
        end
        if (io_valid && m_fifo.size() >= DEPTH) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        if (io_valid && m_fifo.size() < DEPTH) m_fifo.push_back(io_data);
        m_line = nl;
    endtask

    task automatic rx_step();
        int b;
        if (!rx_active && rx_prev && !uart_tx) begin
            rx_active = 1'b1;
            rx_cnt    = 0;
        end
        if (rx_active) begin
            if (rx_cnt % CPB == CPB / 2) begin
                b = rx_cnt / CPB;
                if (b == 0) begin
                    chk("rx_start_bit", uart_tx, 1'b0);
                end else if (b <= 8) begin
                    rx_byte[b-1] = uart_tx;
                end else begin
                    chk("rx_stop_bit", uart_tx, 1'b1);
                    frames++;
                    rx_last = rx_byte;
                    chk("rx_frame_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) chk("rx_byte", rx_byte, exp_q.pop_front());
                    rx_active = 1'b0;
                end
            end
            rx_cnt++;
        end
        rx_prev = uart_tx;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("uart_tx", uart_tx, m_line);
        chk("busy", busy, (m_rem != 0) || (m_fifo.size() != 0));
        chk("fifo_level", fifo_level, m_fifo.size());
        chk("fifo_full", fifo_full, m_fifo.size() == DEPTH);
        chk("overflow", overflow, m_ovf);
        if (int'(fifo_level) > peak) peak = int'(fifo_level);
        rx_step();
    endtask

    task automatic strobe(input logic [7:0] d);
        io_valid = 1'b1;
        io_data  = d;
        tick();
        io_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while ((busy || m_rem != 0 || m_fifo.size() != 0 || rx_active) && n < max_cycles) begin
            tick();
            n++;
        end
        chk("wait_idle_in_budget", n < max_cycles, 1'b1);
        tick();
    endtask

    initial begin
        logic [9:0] pat;
        int f0;
        int n;

        // Reset
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_uart_tx", uart_tx, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_fifo_full", fifo_full, 1'b0);
        chk("reset_fifo_level", fifo_level, 0);
        chk("reset_overflow", overflow, 1'b0);
        rst_n = 1'b1;
        tick();

        // Single byte 0xA5: line 0,1,0,1,0,0,1,0,1,1
        pat = 10'b1101001010;
        strobe(8'hA5);
        chk("single_level_after_push", fifo_level, 1);
        chk("single_tx_high_edge_n", uart_tx, 1'b1);
        tick();
        chk("single_tx_high_edge_n1", uart_tx, 1'b1);
        chk("single_level_after_pop", fifo_level, 0);
        for (int i = 0; i < FRAME; i++) begin
            tick();
            chk("single_line_bit", uart_tx, pat[i / CPB]);
            chk("single_busy", busy, i < FRAME - 1);
        end
        wait_idle(100);
        chk("single_frames", frames, 1);
        chk("single_rx_byte", rx_last, 8'hA5);

        // Burst of three consecutive strobes
        peak = 0;
        f0   = frames;
        strobe(8'h01);
        strobe(8'h02);
        strobe(8'h03);
        wait_idle(400);
        chk("burst_peak_level", peak, 2);
        chk("burst_frames", frames - f0, 3);

        // Overflow: ten consecutive strobes from idle
        f0 = frames;
        for (int i = 0; i < 10; i++) strobe(8'($urandom_range(0, 255)));
        chk("ovf_flag_set", overflow, 1'b1);
        chk("ovf_level_full", fifo_level, DEPTH);
        chk("ovf_full_flag", fifo_full, 1'b1);
        wait_idle(1000);
        chk("ovf_frames", frames - f0, 9);
        chk("ovf_flag_sticky", overflow, 1'b1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_flag_cleared", overflow, 1'b0);

        // Full FIFO plus strobe on the final STOP cycle
        f0 = frames;
        for (int i = 0; i < 9; i++) strobe(8'($urandom_range(0, 255)));
        n = 0;
        while (m_rem != 1 && n < FRAME + 4) begin
            tick();
            n++;
        end
        chk("fullpop_reached_stop", m_rem, 1);
        chk("fullpop_level_before", fifo_level, DEPTH);
        strobe(8'h6C);
        chk("fullpop_level_after", fifo_level, DEPTH);
        chk("fullpop_no_overflow", overflow, 1'b0);
        wait_idle(1000);
        chk("fullpop_frames", frames - f0, 10);

        // Reset during data bit 3 of 0xC3 (bit 3 is 0), with bytes queued
        strobe(8'hC3);
        strobe(8'h11);
        strobe(8'h22);
        n = 0;
        while ((FRAME - m_rem) != 4 * CPB + 1 && n < FRAME + 4) begin
            tick();
            n++;
        end
        chk("midreset_line_low_in_bit3", uart_tx, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("midreset_uart_tx", uart_tx, 1'b1);
        chk("midreset_level", fifo_level, 0);
        chk("midreset_busy", busy, 1'b0);
        m_fifo.delete();
        exp_q.delete();
        m_rem     = 0;
        m_ovf     = 1'b0;
        m_line    = 1'b1;
        rx_active = 1'b0;
        rx_prev   = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        f0 = frames;
        strobe(8'h5A);
        wait_idle(200);
        chk("post_reset_frames", frames - f0, 1);
        chk("post_reset_rx_byte", rx_last, 8'h5A);

        // Randomized strobes, gaps and clears
        for (int i = 0; i < 40; i++) begin
            io_valid = 1'b1;
            io_data  = 8'($urandom_range(0, 255));
            ovf_clr  = ($urandom_range(0, 7) == 0);
            tick();
            io_valid = 1'b0;
            ovf_clr  = 1'b0;
            n = $urandom_range(0, 60);
            for (int j = 0; j < n; j++) begin
                ovf_clr = ($urandom_range(0, 31) == 0);
                tick();
                ovf_clr = 1'b0;
            end
        end
        wait_idle(4000);
        chk("final_all_frames_received", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
